instruction_cache: RTL

Direct-mapped, word-per-line instruction cache between the fetch stage and the memory controller. The fetch stage presents a PC and a fetch request. A hit returns the instruction one cycle later. A miss issues a word read to the memory controller, refills the line, then returns the instruction. A branch-mispredict rollback cancels the outstanding fetch without corrupting the cache.

---
 rtl/instruction_cache_pkg.sv | 31 +++
 rtl/icache_storage.sv | 73 +++++++
 rtl/instruction_cache.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// -----------------------------------------------------------------------------
// instruction_cache_pkg
//
// Shared constants for the instruction cache and its storage sub-module:
//   - IC_DEFAULT_INDEX_WIDTH : default log2 of the line count (256 lines)
//   - IC_WORD_WIDTH          : width of an instruction word and of an address
//   - ic_state_e             : controller FSM encodings (IDLE / MISS / DISCARD)
//   - ic_word_align()        : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package instruction_cache_pkg;

    localparam int unsigned IC_DEFAULT_INDEX_WIDTH = 8;
    localparam int unsigned IC_WORD_WIDTH          = 32;

    // IDLE    : can accept a fetch; hits are answered from here
    // MISS    : word read outstanding, result goes to the fetch stage
    // DISCARD : word read outstanding after a rollback; result only fills
    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_MISS    = 2'd1,
        IC_DISCARD = 2'd2
    } ic_state_e;

    // Word-aligned address as presented to the memory controller.
    function automatic logic [IC_WORD_WIDTH-1:0] ic_word_align(
        input logic [IC_WORD_WIDTH-1:0] addr
    );
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage : instruction_cache_pkg

// File: rtl/icache_storage.sv
// -----------------------------------------------------------------------------
// icache_storage
//
// Line storage for the direct-mapped, one-word-per-line instruction cache.
// Tag and data live in plain arrays with no reset; the valid bits live in a
// flat register vector so that reset can clear every line in one cycle.
//
// Ports:
//   clk_in      : clock
//   rst_in      : synchronous active-high reset, clears all valid bits
//   rd_index_i  : combinational read port index
//   rd_valid_o  : valid bit of the addressed line
//   rd_tag_o    : stored tag of the addressed line
//   rd_data_o   : stored instruction word of the addressed line
//   wr_en_i     : write strobe (one line per cycle)
//   wr_index_i  : line to write
//   wr_tag_i    : tag to store
//   wr_data_i   : instruction word to store; the line becomes valid
//
// A write becomes visible on the read port from the following cycle, so a
// lookup in the same cycle as a refill sees the old line contents.
// -----------------------------------------------------------------------------
module icache_storage
    import instruction_cache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = IC_DEFAULT_INDEX_WIDTH,
    parameter int unsigned TAG_WIDTH   = 30 - INDEX_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [INDEX_WIDTH-1:0]   rd_index_i,
    output logic                     rd_valid_o,
    output logic [TAG_WIDTH-1:0]     rd_tag_o,
    output logic [IC_WORD_WIDTH-1:0] rd_data_o,
    input  logic                     wr_en_i,
    input  logic [INDEX_WIDTH-1:0]   wr_index_i,
    input  logic [TAG_WIDTH-1:0]     wr_tag_i,
    input  logic [IC_WORD_WIDTH-1:0] wr_data_i
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;

    logic [TAG_WIDTH-1:0]     tag_mem  [LINES];
    logic [IC_WORD_WIDTH-1:0] data_mem [LINES];
    logic [LINES-1:0]         valid_q;
    logic [LINES-1:0]         wr_sel;

    // One-hot decode of the write index, used to set the matching valid bit.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en_i && (wr_index_i == INDEX_WIDTH'(gi));
    end

    always_ff @(posedge clk_in) begin
        if (wr_en_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_data_i;
        end
    end

    // Lines are only ever invalidated by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | wr_sel;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[rd_index_i];

endmodule : icache_storage

// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, one-word-per-line instruction cache between the fetch stage
// and the memory controller. A hit answers one cycle after the request; a miss
// issues a single word read, refills the line and then answers. A rollback
// cancels the fetch in flight, but a read already issued is still allowed to
// complete and fill its line (the controller cannot abort it).
//
// Ports:
//   clk_in          : clock
//   rst_in          : synchronous active-high reset
//   rdy_in          : global ready; low freezes all state, array and outputs
//   fetch_start     : fetch request for pc_in
//   pc_in           : fetch address, bits [1:0] ignored
//   roll_back       : cancel the current fetch
//   is_idle         : controller idle, request can be accepted this cycle
//   finish_fetch    : one-cycle pulse, instruction_out valid
//   instruction_out : fetched instruction
//   mem_req         : word read request, held until mem_done
//   mem_addr        : word-aligned read address, stable while mem_req
//   mem_done        : one-cycle pulse, mem_data valid
//   mem_data        : word returned by memory
// -----------------------------------------------------------------------------
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = IC_DEFAULT_INDEX_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     fetch_start,
    input  logic [IC_WORD_WIDTH-1:0] pc_in,
    input  logic                     roll_back,
    output logic                     is_idle,
    output logic                     finish_fetch,
    output logic [IC_WORD_WIDTH-1:0] instruction_out,
    output logic                     mem_req,
    output logic [IC_WORD_WIDTH-1:0] mem_addr,
    input  logic                     mem_done,
    input  logic [IC_WORD_WIDTH-1:0] mem_data
);

    localparam int unsigned TAG_WIDTH = 30 - INDEX_WIDTH;

    ic_state_e                state_q,    state_d;
    logic [29:0]              pc_q,       pc_d;       // word address of the miss
    logic                     finish_q,   finish_d;
    logic [IC_WORD_WIDTH-1:0] instr_q,    instr_d;
    logic                     mem_req_q,  mem_req_d;
    logic [IC_WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [INDEX_WIDTH-1:0]   req_index;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic [INDEX_WIDTH-1:0]   fill_index;
    logic [TAG_WIDTH-1:0]     fill_tag;

    logic                     rd_valid;
    logic [TAG_WIDTH-1:0]     rd_tag;
    logic [IC_WORD_WIDTH-1:0] rd_data;
    logic                     hit;
    logic                     fill_en;

    assign req_index  = pc_in[INDEX_WIDTH+1:2];
    assign req_tag    = pc_in[31:INDEX_WIDTH+2];
    assign fill_index = pc_q[INDEX_WIDTH-1:0];
    assign fill_tag   = pc_q[29:INDEX_WIDTH];

    assign hit = rd_valid && (rd_tag == req_tag);

    // The returning word fills the line whether or not the fetch was rolled
    // back. mem_done is meaningless while rdy_in is low, and a reset in the
    // same cycle wins over the fill.
    assign fill_en = rdy_in && !rst_in && mem_done &&
                     ((state_q == IC_MISS) || (state_q == IC_DISCARD));

    icache_storage #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_storage (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rd_index_i (req_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_index_i (fill_index),
        .wr_tag_i   (fill_tag),
        .wr_data_i  (mem_data)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        finish_d   = 1'b0;
        instr_d    = instr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            IC_IDLE: begin
                // A rollback in the same cycle blocks acceptance, which also
                // keeps finish_fetch low in the following cycle.
                if (fetch_start && !roll_back) begin
                    if (hit) begin
                        finish_d = 1'b1;
                        instr_d  = rd_data;
                    end else begin
                        pc_d       = pc_in[31:2];
                        mem_req_d  = 1'b1;
                        mem_addr_d = ic_word_align(pc_in);
                        state_d    = IC_MISS;
                    end
                end
            end

            IC_MISS: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = IC_IDLE;
                    if (!roll_back) begin
                        finish_d = 1'b1;
                        instr_d  = mem_data;
                    end
                end else if (roll_back) begin
                    state_d = IC_DISCARD;
                end
            end

            IC_DISCARD: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = IC_IDLE;
                end
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = IC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IC_IDLE;
            pc_q       <= '0;
            finish_q   <= 1'b0;
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            finish_q   <= finish_d;
            instr_q    <= instr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign is_idle         = (state_q == IC_IDLE);
    assign finish_fetch    = finish_q;
    assign instruction_out = instr_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;

endmodule : instruction_cache
